if_prefetch: RTL and testbench

Instruction-fetch stage with a small prefetch queue. It sits directly upstream of the pipeline's ID stage and produces the pc / instr_id pair that ID decodes. It issues sequential fetches to instruction memory over a req/ack handshake and buffers the returned words. It absorbs ID stalls and flushes on branch/jump redirects from EX.

---
 rtl/if_prefetch.sv | 153 +++++++++++++++
 tb/tb_if_prefetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: sequential imem fetches into a small prefetch FIFO feeding the ID register.
// Optional macro IF_BYPASS_EN: an ack that finds the FIFO empty loads the ID register directly.
module if_prefetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_0,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr_id,
  output logic              instr_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] fifo_pc    [DEPTH];
  logic [31:0]       fifo_instr [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;

  logic              outstanding, discard;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next, req_addr;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;

  logic ack_valid, fifo_empty, bypass, push, pop, req_free, issue;

  assign ack_valid  = outstanding & imem_ack;
  assign fifo_empty = (count == '0);

`ifdef IF_BYPASS_EN
  assign bypass = ack_valid & ~discard & ~redirect & ~id_stall & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = ack_valid & ~discard & ~redirect & ~bypass;
  assign pop  = ~redirect & ~id_stall & ~fifo_empty;

  // Occupancy after this edge; a redirect discards everything queued.
  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect)
      fetch_pc_next = redirect_pc & ~ADDR_W'(3);
    else if (ack_valid && !discard)
      fetch_pc_next = fetch_pc + ADDR_W'(4);
  end

  // A new request can follow an ack on the same edge, but never during a redirect edge.
  assign req_free = ~outstanding | ack_valid;
  assign issue    = req_free & ~redirect & (count_next < DEPTH_C);

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc_next;
      end else if (ack_valid) begin
        outstanding <= 1'b0;
      end
      if (redirect)
        discard <= outstanding & ~imem_ack;
      else if (ack_valid)
        discard <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_addr;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (redirect) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (bypass) begin
      pc_q    <= req_addr;
      instr_q <= imem_rdata;
      valid_q <= 1'b1;
    end else if (!id_stall) begin
      if (pop) begin
        pc_q    <= fifo_pc[rd_ptr];
        instr_q <= fifo_instr[rd_ptr];
        valid_q <= 1'b1;
      end else begin
        instr_q <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_req    = outstanding;
  assign imem_addr   = req_addr;
  assign pc          = pc_q;
  assign instr_id    = instr_q;
  assign instr_valid = valid_q;

  // The issue limit guarantees a push never lands on a full FIFO.
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_0)
                                   !(push && count == DEPTH_C));

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch (default build): per-cycle vector table plus an async-reset sequence.
module tb_if_prefetch;

  logic        clock = 1'b0;
  logic        reset_0 = 1'b0;
  logic        imem_ack = 1'b0;
  logic        redirect = 1'b0;
  logic        id_stall = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr_id;
  logic        instr_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  if_prefetch #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_0(reset_0),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .pc(pc), .instr_id(instr_id), .instr_valid(instr_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory returns a word derived from the address it is asked for.
  assign imem_rdata = word_of(imem_addr);

  task automatic add(input logic rst, input logic ack, input logic stall, input logic redir,
                     input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                     input logic valid, input logic [31:0] epc, input logic [31:0] instr);
    vec_t v;
    v = '{rst, ack, stall, redir, rpc, req, addr, valid, epc, instr};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int step);
    @(negedge clock);
    reset_0     = ~v.rst;
    imem_ack    = v.ack;
    id_stall    = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    @(posedge clock);
    #1;
    checkOutput("imem_req",    step, {31'b0, imem_req},    {31'b0, v.req});
    checkOutput("imem_addr",   step, imem_addr,            v.addr);
    checkOutput("instr_valid", step, {31'b0, instr_valid}, {31'b0, v.valid});
    checkOutput("pc",          step, pc,                   v.pc);
    checkOutput("instr_id",    step, instr_id,             v.instr);
  endtask

  initial begin
    // Streaming from reset with single-cycle acks.
    add(0,0,0,0,0,  1,32'h0,  0,32'h0,0);
    add(0,1,0,0,0,  1,32'h4,  0,32'h0,0);
    add(0,1,0,0,0,  1,32'h8,  1,32'h0,word_of(32'h0));
    add(0,1,0,0,0,  1,32'hC,  1,32'h4,word_of(32'h4));
    add(0,1,0,0,0,  1,32'h10, 1,32'h8,word_of(32'h8));
    add(1,0,0,0,0,  0,32'h0,  0,32'h0,0);
    // Ten stalled cycles: four fetches fill the queue, then the request stays low.
    add(0,0,1,0,0,  1,32'h0,  0,32'h0,0);
    add(0,1,1,0,0,  1,32'h4,  0,32'h0,0);
    add(0,1,1,0,0,  1,32'h8,  0,32'h0,0);
    add(0,1,1,0,0,  1,32'hC,  0,32'h0,0);
    add(0,1,1,0,0,  0,32'hC,  0,32'h0,0);
    add(0,1,1,0,0,  0,32'hC,  0,32'h0,0);
    for (int i = 0; i < 4; i++) add(0,0,1,0,0, 0,32'hC, 0,32'h0,0);
    // Release: four queued instructions drain in order, fetching resumes at 0x10.
    add(0,0,0,0,0,  1,32'h10, 1,32'h0,word_of(32'h0));
    add(0,0,0,0,0,  1,32'h10, 1,32'h4,word_of(32'h4));
    add(0,0,0,0,0,  1,32'h10, 1,32'h8,word_of(32'h8));
    add(0,0,0,0,0,  1,32'h10, 1,32'hC,word_of(32'hC));
    add(0,0,0,0,0,  1,32'h10, 0,32'hC,0);
    add(0,1,0,0,0,  1,32'h14, 0,32'hC,0);
    add(0,0,0,0,0,  1,32'h14, 1,32'h10,word_of(32'h10));
    add(1,0,0,0,0,  0,32'h0,  0,32'h0,0);
    // Redirect to 0x41 (aligned to 0x40) while 0x0C is outstanding; its ack arrives 3 cycles later.
    add(0,0,0,0,0,  1,32'h0,  0,32'h0,0);
    add(0,1,0,0,0,  1,32'h4,  0,32'h0,0);
    add(0,1,0,0,0,  1,32'h8,  1,32'h0,word_of(32'h0));
    add(0,1,0,0,0,  1,32'hC,  1,32'h4,word_of(32'h4));
    add(0,0,0,1,32'h41, 1,32'hC, 0,32'h4,0);
    add(0,0,0,0,0,  1,32'hC,  0,32'h4,0);
    add(0,0,0,0,0,  1,32'hC,  0,32'h4,0);
    add(0,1,0,0,0,  1,32'h40, 0,32'h4,0);
    add(0,1,0,0,0,  1,32'h44, 0,32'h4,0);
    add(0,0,0,0,0,  1,32'h44, 1,32'h40,word_of(32'h40));
    // Redirect together with stall and ack, then straight-line fetch across the address wrap.
    add(0,1,1,0,0,  1,32'h48, 1,32'h40,word_of(32'h40));
    add(0,1,1,1,32'hFFFF_FFFC, 0,32'h48, 0,32'h40,0);
    add(0,0,1,0,0,  1,32'hFFFF_FFFC, 0,32'h40,0);
    add(0,1,0,0,0,  1,32'h0,  0,32'h40,0);
    add(0,1,0,0,0,  1,32'h4,  1,32'hFFFF_FFFC,word_of(32'hFFFF_FFFC));
    add(0,0,0,0,0,  1,32'h4,  1,32'h0,word_of(32'h0));

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_req",   0, {31'b0, imem_req},    32'h0);
    checkOutput("rst_addr",  0, imem_addr,            32'h0);
    checkOutput("rst_valid", 0, {31'b0, instr_valid}, 32'h0);
    checkOutput("rst_pc",    0, pc,                   32'h0);
    checkOutput("rst_instr", 0, instr_id,             32'h0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i + 1);

    // Asynchronous reset mid-request, away from any clock edge.
    @(negedge clock);
    #2;
    checkOutput("pre_reset_req", 100, {31'b0, imem_req}, 32'h1);
    reset_0  = 1'b0;
    imem_ack = 1'b0;
    #1;
    checkOutput("async_req_drop",  101, {31'b0, imem_req},    32'h0);
    checkOutput("async_addr",      101, imem_addr,            32'h0);
    checkOutput("async_valid",     101, {31'b0, instr_valid}, 32'h0);
    applyStimulus('{0,0,0,0,32'h0, 1,32'h0, 0,32'h0,32'h0}, 102);
    applyStimulus('{0,1,0,0,32'h0, 1,32'h4, 0,32'h0,32'h0}, 103);
    applyStimulus('{0,1,0,0,32'h0, 1,32'h8, 1,32'h0,word_of(32'h0)}, 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
